// File: rtl/hamming_secded_scrubber.sv
// SECDED (22,16) decode/scrub stage: two-register pipeline with valid/ready backpressure,
// single-error correction, double-error flagging and saturating error statistics.
module hamming_secded_scrubber #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [21:0]      cw_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      data_out,
  output logic             err_single,
  output logic             err_double,
  output logic [4:0]       err_pos,
  output logic [CNT_W-1:0] cnt_single,
  output logic [CNT_W-1:0] cnt_double,
  input  logic             clr_cnt
);

  logic        s1_valid;
  logic [21:0] s1_cw;
  logic [4:0]  s1_syn;
  logic        s1_par;
  logic        s1_ready;
  logic        s2_ready;

  logic [4:0]  syn_in;
  logic [21:0] fixed_cw;
  logic        cls_single;
  logic        cls_double;
  logic [4:0]  cls_pos;
  logic        xfer;

  // Data bits sit at the non-power-of-two Hamming positions, d0 at position 3.
  function automatic logic [15:0] extract_data(input logic [21:0] w);
    return {w[20:16], w[14:8], w[6:4], w[2]};
  endfunction

  assign s2_ready = !out_valid || out_ready;
  assign s1_ready = !s1_valid || s2_ready;
  assign in_ready = s1_ready;
  assign xfer     = out_valid && out_ready;

  always_comb begin
    syn_in = '0;
    for (int i = 1; i <= 21; i++) begin
      if (cw_in[i-1]) syn_in = syn_in ^ i[4:0];
    end
  end

  always_comb begin
    fixed_cw   = s1_cw;
    cls_single = 1'b0;
    cls_double = 1'b0;
    cls_pos    = '0;
    if (s1_syn == 5'd0) begin
      cls_single = s1_par;
    end else if (s1_par && (s1_syn <= 5'd21)) begin
      cls_single = 1'b1;
      cls_pos    = s1_syn;
      fixed_cw   = s1_cw ^ (22'd1 << (s1_syn - 5'd1));
    end else begin
      // Even-weight error, or odd-weight pattern pointing outside the codeword.
      cls_double = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      s1_cw      <= '0;
      s1_syn     <= '0;
      s1_par     <= 1'b0;
      out_valid  <= 1'b0;
      data_out   <= '0;
      err_single <= 1'b0;
      err_double <= 1'b0;
      err_pos    <= '0;
    end else begin
      if (s1_ready) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_cw  <= cw_in;
          s1_syn <= syn_in;
          s1_par <= ^cw_in;
        end
      end
      if (s2_ready) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          data_out   <= extract_data(fixed_cw);
          err_single <= cls_single;
          err_double <= cls_double;
          err_pos    <= cls_pos;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr_cnt) begin
      cnt_single <= '0;
      cnt_double <= '0;
    end else if (xfer) begin
      if (err_single && (cnt_single != {CNT_W{1'b1}})) cnt_single <= cnt_single + CNT_W'(1);
      if (err_double && (cnt_double != {CNT_W{1'b1}})) cnt_double <= cnt_double + CNT_W'(1);
    end
  end

endmodule
